// File: rtl/pe_scheduler.sv
// PE scheduler: tracks resident filter/ifmap rows and issues one MAC command
// per (filter row, output column) pair once the working set is complete.
module pe_scheduler #(
    parameter  int FILTER_WIDTH = 8,
    parameter  int IFMAP_SIZE   = 9,
    localparam int NCOL         = IFMAP_SIZE - 2,
    localparam int CW           = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_ifmapb_filter,
    input  logic [1:0]    in_filter_row,
    input  logic          in_timestep,
    output logic [2:0]    filt_wr,
    output logic          ifmap_wr,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_row,
    output logic [CW-1:0] cmd_col,
    output logic          cmd_timestep,
    output logic          done,
    output logic          err
);

    // Weight width only matters to the datapath; rejected here if nonsensical.
    if (FILTER_WIDTH < 1) begin : g_bad_filter_width
        $error("pe_scheduler: FILTER_WIDTH must be at least 1");
    end
    if (IFMAP_SIZE < 3 || IFMAP_SIZE > 64) begin : g_bad_ifmap_size
        $error("pe_scheduler: IFMAP_SIZE must be in 3..64");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [2:0]      filt_loaded_reg;
    logic            ifmap_loaded_reg;
    logic [1:0]      row_reg;
    logic [CW-1:0]   col_reg;
    logic            ts_reg;
    logic            err_reg;

    logic            acc;
    logic            filt_acc;
    logic            cmd_fire;
    logic            col_last;
    logic            last_cmd;

    assign in_ready = (state_reg == S_IDLE);
    assign acc      = in_valid & in_ready;
    assign filt_acc = acc & in_ifmapb_filter;
    assign ifmap_wr = acc & ~in_ifmapb_filter;

    // Row 3 matches no strobe, so an illegal header writes nothing.
    for (genvar gi = 0; gi < 3; gi++) begin : g_filt_wr
        assign filt_wr[gi] = filt_acc & (in_filter_row == 2'(gi));
    end

    assign cmd_fire = (state_reg == S_RUN) & cmd_ready;
    assign col_last = (col_reg == CW'(NCOL - 1));
    assign last_cmd = (row_reg == 2'd2) & col_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if ((&filt_loaded_reg) && ifmap_loaded_reg) state_next = S_RUN;
            S_RUN:  if (cmd_fire && last_cmd) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_loaded_reg  <= 3'b000;
            ifmap_loaded_reg <= 1'b0;
            row_reg          <= 2'd0;
            col_reg          <= '0;
            ts_reg           <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            err_reg         <= filt_acc & (in_filter_row == 2'd3);
            filt_loaded_reg <= filt_loaded_reg | filt_wr;

            if (ifmap_wr) begin
                ifmap_loaded_reg <= 1'b1;
                ts_reg           <= in_timestep;
            end else if (state_reg == S_DONE) begin
                ifmap_loaded_reg <= 1'b0;
            end

            // Counters wrap to zero on the final command so DONE shows (0,0).
            if (state_reg == S_DONE) begin
                row_reg <= 2'd0;
                col_reg <= '0;
            end else if (cmd_fire) begin
                if (last_cmd) begin
                    row_reg <= 2'd0;
                    col_reg <= '0;
                end else if (col_last) begin
                    row_reg <= row_reg + 2'd1;
                    col_reg <= '0;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

    assign cmd_valid    = (state_reg == S_RUN);
    assign cmd_row      = row_reg;
    assign cmd_col      = col_reg;
    assign cmd_timestep = ts_reg;
    assign done         = (state_reg == S_DONE);
    assign err          = err_reg;

endmodule

// File: tb/tb_pe_scheduler.sv
// Bench for pe_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pe_scheduler;

    localparam int NCOL  = 7;
    localparam int NCMDS = 3 * NCOL;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_ifmapb_filter;
    logic [1:0] in_filter_row;
    logic       in_timestep;
    logic [2:0] filt_wr;
    logic       ifmap_wr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_row;
    logic [2:0] cmd_col;
    logic       cmd_timestep;
    logic       done;
    logic       err;

    pe_scheduler #(.FILTER_WIDTH(8), .IFMAP_SIZE(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_ifmapb_filter (in_ifmapb_filter),
        .in_filter_row    (in_filter_row),
        .in_timestep      (in_timestep),
        .filt_wr          (filt_wr),
        .ifmap_wr         (ifmap_wr),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_row          (cmd_row),
        .cmd_col          (cmd_col),
        .cmd_timestep     (cmd_timestep),
        .done             (done),
        .err              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: flags for resident rows, a queue of outstanding commands.
    bit [2:0] m_filt;
    bit       m_ifmap, m_ts, m_busy, m_done, m_err;
    int       exp_q[$];
    int       cmd_log[$];
    int       cmd_cnt = 0, valid_cycles = 0, done_cnt = 0, err_cnt = 0;

    initial begin : compare
        bit       s_valid, s_filt, s_ts, s_cready, s_ready, s_acc, start;
        bit [1:0] s_row;
        logic [2:0] exp_fw;
        m_filt = 0; m_ifmap = 0; m_ts = 0; m_busy = 0; m_done = 0; m_err = 0;
        forever begin
            @(negedge clk);
            s_ready = !m_busy && !m_done;
            if (!rst) begin
                exp_fw = (in_valid && s_ready && in_ifmapb_filter && in_filter_row != 2'd3)
                         ? (3'b001 << in_filter_row) : 3'b000;
                chk("in_ready", 32'(in_ready), 32'(s_ready));
                chk("filt_wr", 32'(filt_wr), 32'(exp_fw));
                chk("ifmap_wr", 32'(ifmap_wr), 32'(in_valid && s_ready && !in_ifmapb_filter));
                chk("cmd_valid", 32'(cmd_valid), 32'(m_busy));
                chk("done", 32'(done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                chk("cmd_timestep", 32'(cmd_timestep), 32'(m_ts));
                if (m_busy && exp_q.size() > 0) begin
                    chk("cmd_row", 32'(cmd_row), 32'(exp_q[0] / 16));
                    chk("cmd_col", 32'(cmd_col), 32'(exp_q[0] % 16));
                end
                if (cmd_valid === 1'b1) valid_cycles++;
                if (cmd_valid === 1'b1 && cmd_ready) begin
                    cmd_cnt++;
                    cmd_log.push_back(int'(cmd_row) * 16 + int'(cmd_col));
                end
                if (done === 1'b1) done_cnt++;
                if (err === 1'b1) err_cnt++;
            end
            s_valid = in_valid; s_filt = in_ifmapb_filter; s_row = in_filter_row;
            s_ts = in_timestep; s_cready = cmd_ready;
            @(posedge clk);
            if (rst) begin
                m_filt = 0; m_ifmap = 0; m_ts = 0; m_busy = 0; m_done = 0; m_err = 0;
                exp_q.delete();
            end else begin
                s_acc = s_valid && s_ready;
                m_err = s_acc && s_filt && s_row == 2'd3;
                if (m_done) begin
                    m_done  = 0;
                    m_ifmap = 0;
                end else if (m_busy) begin
                    if (s_cready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            m_busy = 0;
                            m_done = 1;
                        end
                    end
                end else begin
                    start = (&m_filt) && m_ifmap;
                    if (s_acc && s_filt && s_row != 2'd3) m_filt[s_row] = 1;
                    if (s_acc && !s_filt) begin
                        m_ifmap = 1;
                        m_ts    = s_ts;
                    end
                    if (start) begin
                        m_busy = 1;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < NCOL; c++)
                                exp_q.push_back(r * 16 + c);
                    end
                end
            end
        end
    end

    // cmd_ready driver: constant 1 or the stall pattern 1,0,0,1.
    bit toggle_mode = 0;
    initial begin : ready_drv
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int pidx = 0;
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                cmd_ready = pat[pidx % 4];
                pidx++;
            end else begin
                cmd_ready = 1'b1;
            end
        end
    end

    logic [2:0] last_fw;

    task automatic send(input bit is_filt, input logic [1:0] row, input bit ts);
        bit got = 0;
        in_valid = 1'b1; in_ifmapb_filter = is_filt; in_filter_row = row; in_timestep = ts;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        last_fw = filt_wr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("ready_after_done", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c0, v0, d0, e0, l0;

    initial begin : stim
        rst = 0; in_valid = 0; in_ifmapb_filter = 0; in_filter_row = 0; in_timestep = 0;
        #2 rst = 1;
        idle(2);
        rst = 0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ts", 32'(cmd_timestep), 0);
        @(posedge clk); #1;

        // Pass 1: filters 0,1,2 then ifmap ts=1, cmd_ready held high.
        c0 = cmd_cnt; v0 = valid_cycles; d0 = done_cnt; l0 = cmd_log.size();
        send(1, 0, 0); send(1, 1, 0); send(1, 2, 0); send(0, 0, 1);
        @(negedge clk);
        chk("latency_idle_cycle", 32'(cmd_valid), 0);
        @(negedge clk);
        chk("latency_first_cmd", 32'(cmd_valid), 1);
        chk("pass1_ts", 32'(cmd_timestep), 1);
        @(posedge clk); #1;
        wait_done(100);
        chk("pass1_cmds", 32'(cmd_cnt - c0), NCMDS);
        chk("pass1_run_cycles", 32'(valid_cycles - v0), NCMDS);
        chk("pass1_done_pulses", 32'(done_cnt - d0), 1);
        if (cmd_log.size() >= l0 + NCMDS) begin
            chk("pass1_first", 32'(cmd_log[l0]), 32'h00);
            chk("pass1_row1_start", 32'(cmd_log[l0 + 7]), 32'h10);
            chk("pass1_last", 32'(cmd_log[l0 + 20]), 32'h26);
        end else begin
            chk("pass1_log_len", 32'(cmd_log.size() - l0), NCMDS);
        end

        // Pass 2: filters stay resident, only a new ifmap with ts=0.
        c0 = cmd_cnt; d0 = done_cnt;
        send(0, 0, 0);
        idle(2);
        chk("pass2_ts", 32'(cmd_timestep), 0);
        wait_done(100);
        chk("pass2_cmds", 32'(cmd_cnt - c0), NCMDS);
        chk("pass2_done_pulses", 32'(done_cnt - d0), 1);

        // Pass 3: stalls from the 1,0,0,1 cmd_ready pattern.
        c0 = cmd_cnt; v0 = valid_cycles; d0 = done_cnt;
        toggle_mode = 1;
        send(0, 0, 1);
        wait_done(300);
        toggle_mode = 0;
        chk("pass3_cmds", 32'(cmd_cnt - c0), NCMDS);
        chk("pass3_stalled", 32'(valid_cycles - v0 > NCMDS), 1);
        chk("pass3_done_pulses", 32'(done_cnt - d0), 1);
        idle(1);

        // Reset in the middle of a pass at command (1,3).
        d0 = done_cnt;
        send(0, 0, 1);
        begin
            bit hit = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (cmd_valid === 1'b1 && cmd_row == 2'd1 && cmd_col == 3'd3) begin
                    hit = 1;
                    break;
                end
            end
            if (!hit) chk("reach_cmd_1_3", 0, 1);
        end
        #1 rst = 1;
        #1;
        chk("midrst_cmd_valid", 32'(cmd_valid), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_row", 32'(cmd_row), 0);
        chk("midrst_col", 32'(cmd_col), 0);
        chk("midrst_ts", 32'(cmd_timestep), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        v0 = valid_cycles;
        send(0, 0, 0);
        idle(30);
        chk("after_rst_no_run", 32'(valid_cycles - v0), 0);
        chk("after_rst_no_done", 32'(done_cnt - d0), 0);

        // Ifmap already loaded; filters arrive 2,0,1.
        c0 = cmd_cnt;
        send(1, 2, 0);
        chk("fw_row2", 32'(last_fw), 32'b100);
        send(1, 0, 0);
        chk("fw_row0", 32'(last_fw), 32'b001);
        idle(3);
        chk("no_run_before_row1", 32'(valid_cycles - v0), 0);
        send(1, 1, 0);
        chk("fw_row1", 32'(last_fw), 32'b010);
        wait_done(100);
        chk("pass4_cmds", 32'(cmd_cnt - c0), NCMDS);

        // Illegal row 3 header.
        rst = 1;
        idle(1);
        rst = 0;
        e0 = err_cnt; v0 = valid_cycles; c0 = cmd_cnt;
        send(0, 0, 1); send(1, 0, 0); send(1, 1, 0); send(1, 3, 0);
        chk("fw_row3", 32'(last_fw), 32'b000);
        idle(5);
        chk("err_pulses", 32'(err_cnt - e0), 1);
        chk("no_run_after_bad_row", 32'(valid_cycles - v0), 0);
        send(1, 2, 0);
        wait_done(100);
        chk("pass5_cmds", 32'(cmd_cnt - c0), NCMDS);
        chk("err_total", 32'(err_cnt - e0), 1);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pe_scheduler.md
# pe_scheduler

Synchronous control block for the processing element. It accepts decoded packet headers from the depacketizer and records which of the three filter rows and which ifmap row are resident in the PE datapath. Once a full working set is loaded, it issues one MAC command per (filter row, output column) pair, in row-major order, to the convolution datapath. It then pulses `done` and waits for the next ifmap row; filters stay resident.

## Interface
Parameters:
- FILTER_WIDTH, 8, bit width of one filter weight; pass-through only, sets no control widths.
- IFMAP_SIZE, 9, ifmap row length in spikes; output columns per row `NCOL = IFMAP_SIZE-2`; legal range 3..64.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a decoded packet header is present.
- in_ready  output  1  scheduler can accept a header.
- in_ifmapb_filter  input  1  1 = filter packet, 0 = ifmap packet.
- in_filter_row  input  2  filter row index 0..2; value 3 is illegal.
- in_timestep  input  1  timestep tag of an ifmap packet.
- filt_wr  output  3  one-hot write strobe to filter row register 0..2.
- ifmap_wr  output  1  write strobe to the ifmap row register.
- cmd_valid  output  1  a MAC command is presented.
- cmd_ready  input  1  datapath accepts the command.
- cmd_row  output  2  filter row of the command.
- cmd_col  output  $clog2(IFMAP_SIZE-2) (min 1)  output column of the command.
- cmd_timestep  output  1  latched timestep of the active ifmap.
- done  output  1  one-cycle pulse after the last command of a row pass.
- err  output  1  one-cycle pulse on an illegal filter row header.

## Operation
- States:
  - IDLE: load headers.
  - RUN: issue commands.
  - DONE: one-cycle completion state.
- Accept condition: `acc = in_valid & in_ready`. `in_ready = (state==IDLE)`, combinational.
- Filter header with row r in 0..2: on acc, `filt_wr[r]=1` in the same cycle (combinational, so the datapath captures the data with the handshake). `filt_loaded[r]` is set at the clock edge.
- Filter header with row 3: the header is consumed. `filt_wr` stays 0, `filt_loaded` is unchanged, and `err=1` in the next cycle.
- Ifmap header:
  - on acc, `ifmap_wr=1` in the same cycle;
  - `ifmap_loaded` is set and `in_timestep` is latched into `cmd_timestep`;
  - a second ifmap header while in IDLE overwrites both.
- A filter header that repeats a row overwrites it; `filt_loaded` stays set.
- IDLE→RUN: at the first edge where `filt_loaded==3'b111 && ifmap_loaded`, as registered state. Headers accepted in that same cycle are still applied.
- RUN:
  - `cmd_valid=1` for the whole state; `cmd_row` and `cmd_col` come from registered counters, both starting at 0.
  - On `cmd_valid & cmd_ready`, `cmd_col` increments. When it reaches `NCOL-1`, it wraps to 0 and `cmd_row` increments.
  - The accept with `cmd_row==2 && cmd_col==NCOL-1` moves the state to DONE.
  - Command values are held stable while `cmd_ready=0`.
- DONE:
  - `done=1`, `ifmap_loaded` is cleared, counters are zeroed, and the state returns to IDLE;
  - `filt_loaded` is retained, so the next pass needs only a new ifmap header.
- Reset, asynchronous and any time including mid-RUN:
  - state = IDLE, `filt_loaded = 0`, `ifmap_loaded = 0`, counters = 0, `cmd_timestep = 0`;
  - `err = 0`, `done = 0`, `cmd_valid = 0`;
  - `in_ready = 1` once rst deasserts.
  - A pass interrupted by reset is abandoned and no `done` is produced.

## Timing
- Outputs `filt_wr`, `ifmap_wr` and `in_ready` are combinational from state and inputs. `cmd_*`, `done` and `err` are registered or decoded from registered state, with no combinational path from `cmd_ready`.
- Load to first command: 1 cycle after the edge that completes the working set, `cmd_valid` is high.
- With `cmd_ready` held at 1, RUN lasts exactly `3*NCOL` cycles (21 for IFMAP_SIZE=9), followed by 1 DONE cycle.
- Throughput: one command per cycle.
- `in_ready=0` during RUN and DONE; headers are back-pressured there, never dropped.
- `err` and `done` are never asserted together.

## Test plan
- Reset then three filter headers (rows 0,1,2) and one ifmap header with ts=1, `cmd_ready=1`:
  - 21 commands in order (0,0)…(0,6),(1,0)…(2,6), all with `cmd_timestep=1`;
  - `done` pulses once;
  - `in_ready` returns to 1 in the cycle after `done`.
- Ifmap header first, then filters 2,0,1: RUN starts only after the row 1 filter is accepted; `filt_wr` one-hot values are 100, 001, 010.
- `cmd_ready` toggling 1,0,0,1: `cmd_row`/`cmd_col` are held during the stalls, no command is skipped or duplicated, and the 21 commands complete.
- After `done`, a second ifmap header with ts=0 and no new filters: a second pass of 21 commands with `cmd_timestep=0`.
- Filter header with row 3: `err` pulses once, `filt_wr=000`, and RUN does not start until a legal row 2 is loaded.
- rst asserted at command (1,3): all outputs clear immediately and there is no `done`. After release, the ifmap header alone does not start RUN because filters must be reloaded.
